// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit holding HI/LO: fixed-latency multiply and
// multiply-accumulate, one-bit-per-cycle restoring divide, abort on flush.
module mdu_iter #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int CW = $clog2((WIDTH > MULT_LAT) ? WIDTH : MULT_LAT) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   opa;     // multiplicand, or dividend/quotient shift register
  logic [WIDTH-1:0]   opb;     // multiplier, or divisor magnitude
  logic [WIDTH-1:0]   rem;
  logic               q_neg;
  logic               r_neg;
  logic               zero;

  assign busy = (state != IDLE);

  // Launch-time decode
  logic             is_div;
  logic             div_sgn;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign is_div  = (op[2:1] == 2'b01);
  assign div_sgn = (op == 3'd2);
  assign a_mag   = (div_sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag   = (div_sgn && b[WIDTH-1]) ? -b : b;

  // Multiply and accumulate against HI/LO as they stand at completion
  logic                 mul_sgn;
  logic [2*WIDTH-1:0]   ext_a;
  logic [2*WIDTH-1:0]   ext_b;
  logic [2*WIDTH-1:0]   prod;
  logic [2*WIDTH-1:0]   mul_res;

  assign mul_sgn = ~op_q[0];
  assign ext_a   = mul_sgn ? {{WIDTH{opa[WIDTH-1]}}, opa} : {{WIDTH{1'b0}}, opa};
  assign ext_b   = mul_sgn ? {{WIDTH{opb[WIDTH-1]}}, opb} : {{WIDTH{1'b0}}, opb};
  assign prod    = ext_a * ext_b;

  always_comb begin
    mul_res = prod;
    case (op_q)
      3'd4, 3'd5: mul_res = {hi, lo} + prod;
      3'd6, 3'd7: mul_res = {hi, lo} - prod;
      default:    mul_res = prod;
    endcase
  end

  // One restoring shift-subtract step
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign shifted  = {rem, opa[WIDTH-1]};
  assign diff     = shifted - {1'b0, opb};
  assign rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_step = {opa[WIDTH-2:0], ~diff[WIDTH]};
  assign q_fix    = q_neg ? -opa : opa;
  assign r_fix    = r_neg ? -rem : rem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      opa   <= '0;
      opb   <= '0;
      rem   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      zero  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      div0  <= 1'b0;
    end else begin
      div0 <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              op_q <= op;
              if (is_div) begin
                opa   <= a_mag;
                opb   <= b_mag;
                rem   <= '0;
                q_neg <= div_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg <= div_sgn && a[WIDTH-1];
                zero  <= (b == '0);
                cnt   <= CW'(WIDTH - 1);
                state <= (b == '0) ? FIX : DIV;
              end else begin
                opa   <= a;
                opb   <= b;
                cnt   <= CW'(MULT_LAT - 1);
                state <= MUL;
              end
            end else begin
              if (hi_we) hi <= a;
              if (lo_we) lo <= a;
            end
          end
          MUL: begin
            if (cnt == '0) begin
              {hi, lo} <= mul_res;
              state    <= IDLE;
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          DIV: begin
            rem <= rem_step;
            opa <= quo_step;
            if (cnt == '0) state <= FIX;
            else           cnt   <= cnt - CW'(1);
          end
          FIX: begin
            if (zero) begin
              div0 <= 1'b1;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table of single ops plus hand-written
// flush, reset, held-start and back-to-back sequences.
module tb_mdu_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div0;

  int total = 0;
  int bad   = 0;

  mdu_iter #(.WIDTH(32), .MULT_LAT(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .flush(flush),
    .busy(busy), .hi(hi), .lo(lo), .div0(div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi0;
    logic [31:0] lo0;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          ecyc;
    int          ed0;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk); hi_we = 1'b1; a = h;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; a = l;
    @(negedge clk); lo_we = 1'b0;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int cyc, output int d0);
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    cyc = 0; d0 = 0;
    while (busy && cyc < 100) begin
      cyc++;
      d0 += int'(div0);
      @(negedge clk);
    end
    d0 += int'(div0);
    @(negedge clk);
    d0 += int'(div0);
  endtask

  initial begin
    int cyc, d0;
    vecs[0]  = '{3'd0, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 5, 0};
    vecs[1]  = '{3'd1, 32'hFFFFFFFD, 32'd5, 32'h0, 32'h0, 32'h00000004, 32'hFFFFFFF1, 5, 0};
    vecs[2]  = '{3'd3, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 33, 0};
    vecs[3]  = '{3'd2, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 0};
    vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h0, 32'h80000000, 33, 0};
    vecs[5]  = '{3'd5, 32'd1, 32'd1, 32'h1, 32'hFFFFFFFF, 32'h2, 32'h0, 5, 0};
    vecs[6]  = '{3'd6, 32'd1, 32'd1, 32'h2, 32'h0, 32'h1, 32'hFFFFFFFF, 5, 0};
    vecs[7]  = '{3'd2, 32'd9, 32'd0, 32'h11, 32'h22, 32'h11, 32'h22, 1, 1};
    vecs[8]  = '{3'd4, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 0};
    vecs[9]  = '{3'd7, 32'hFFFFFFFF, 32'd2, 32'h0, 32'h10, 32'hFFFFFFFE, 32'h00000012, 5, 0};
    vecs[10] = '{3'd3, 32'hFFFFFFFF, 32'h10, 32'h0, 32'h0, 32'hF, 32'h0FFFFFFF, 33, 0};
    vecs[11] = '{3'd2, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'h1, 32'hFFFFFFFD, 33, 0};
    vecs[12] = '{3'd3, 32'd5, 32'd0, 32'h3, 32'h4, 32'h3, 32'h4, 1, 1};

    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_hi", 64'(hi), 64'h0);
    chk("reset_lo", 64'(lo), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_div0", 64'(div0), 64'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      set_hilo(vecs[i].hi0, vecs[i].lo0);
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, d0);
      $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h busy_cycles=%0d div0_pulses=%0d",
               i, vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, cyc, d0);
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].ehi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].elo));
      chk($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].ecyc));
      chk($sformatf("vec%0d_div0", i), 64'(d0), 64'(vecs[i].ed0));
    end

    // Flush mid-divide together with start and hi_we
    set_hilo(32'h55, 32'h66);
    @(negedge clk); start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1; start = 1'b1; op = 3'd0; hi_we = 1'b1; a = 32'h999; b = 32'd1;
    @(negedge clk); flush = 1'b0; start = 1'b0; hi_we = 1'b0;
    $display("flush mid-div: busy=%0b hi=%h lo=%h", busy, hi, lo);
    chk("flush_busy", 64'(busy), 64'h0);
    chk("flush_hi", 64'(hi), 64'h55);
    chk("flush_lo", 64'(lo), 64'h66);
    repeat (40) @(negedge clk);
    chk("flush_later_hi", 64'(hi), 64'h55);
    chk("flush_later_lo", 64'(lo), 64'h66);

    // Flush on the completing edge of a divide by zero suppresses div0
    @(negedge clk); start = 1'b1; op = 3'd2; a = 32'd9; b = 32'd0;
    @(negedge clk); start = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    $display("flush div0: busy=%0b div0=%0b", busy, div0);
    chk("flushdz_busy", 64'(busy), 64'h0);
    chk("flushdz_div0", 64'(div0), 64'h0);
    @(negedge clk);
    chk("flushdz_div0_late", 64'(div0), 64'h0);

    // Async reset between edges during a multiply
    @(negedge clk); start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    $display("async reset: busy=%0b hi=%h lo=%h", busy, hi, lo);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_hi", 64'(hi), 64'h0);
    chk("arst_lo", 64'(lo), 64'h0);
    #1 rst_n = 1'b1;

    // Start and hi_we held through a multiply; operands change after launch
    @(negedge clk); start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd4; hi_we = 1'b1;
    @(negedge clk); a = 32'h777; b = 32'd9;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    $display("held start: busy_cycles=%0d hi=%h lo=%h", cyc, hi, lo);
    chk("held_cycles", 64'(cyc), 64'd5);
    chk("held_hi", 64'(hi), 64'h0);
    chk("held_lo", 64'(lo), 64'd12);
    // First idle cycle: start (held) wins over hi_we and launches immediately
    op = 3'd1; a = 32'd2; b = 32'd3;
    @(negedge clk); start = 1'b0; hi_we = 1'b0;
    chk("b2b_busy", 64'(busy), 64'h1);
    cyc = 1;
    @(negedge clk);
    while (busy && cyc < 100) begin
      cyc++;
      @(negedge clk);
    end
    $display("back-to-back multu: busy_cycles=%0d hi=%h lo=%h", cyc, hi, lo);
    chk("b2b_cycles", 64'(cyc), 64'd5);
    chk("b2b_hi", 64'(hi), 64'h0);
    chk("b2b_lo", 64'(lo), 64'd6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
